// File: rtl/ser_word_sched_pkg.sv
// Shared types and constants for the serial word scheduler.
// The optional mismatch check is controlled by SER_SCHED_CHECK_EN (see ser_word_sched).
package ser_sched_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHIFT    = 2'd1,
        WAIT_RDY = 2'd2
    } state_t;

    localparam int unsigned IDX_W      = 32;
    localparam int unsigned DEF_WORD_W = 32;

    // Producer id width; fixed at 3 bits for the supported range of up to 8 producers.
    function automatic int unsigned id_width(input int unsigned n);
        return (n <= 8) ? 3 : $clog2(n);
    endfunction

endpackage

// File: rtl/ser_word_sched_rr_pick.sv
// Combinational round-robin picker: first set request after 'last', with wrap.
// Shared by several arbiters, so it carries no state of its own.
module rr_pick #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = 3
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] id,
    output logic          any
);

    logic          hit_hi;
    logic          hit_lo;
    logic [N-1:0]  g_hi;
    logic [N-1:0]  g_lo;
    logic [IW-1:0] id_hi;
    logic [IW-1:0] id_lo;

    // Two passes: lowest request above 'last', otherwise lowest request overall.
    always_comb begin
        hit_hi = 1'b0;
        hit_lo = 1'b0;
        g_hi   = '0;
        g_lo   = '0;
        id_hi  = '0;
        id_lo  = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (req[i] && (i > 32'(last)) && !hit_hi) begin
                hit_hi   = 1'b1;
                g_hi[i]  = 1'b1;
                id_hi    = IW'(i);
            end
            if (req[i] && !hit_lo) begin
                hit_lo   = 1'b1;
                g_lo[i]  = 1'b1;
                id_lo    = IW'(i);
            end
        end
        grant = hit_hi ? g_hi : g_lo;
        id    = hit_hi ? id_hi : id_lo;
        any   = |req;
    end

endmodule

// File: rtl/ser_word_sched.sv
// Round-robin scheduler feeding one word at a time, LSB-first, into the deserializer.
// Define SER_SCHED_CHECK_EN to add the 'mismatch' output comparing returned vs sent word.
module ser_word_sched
    import ser_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned WORD_W   = DEF_WORD_W,
    parameter int unsigned WAIT_MAX = 64
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*WORD_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic                        rx_data,
    output logic                        rx_val,
    output logic [IDX_W-1:0]            index,
    input  logic                        tx_rdy,
    input  logic [WORD_W-1:0]           tx_data,
    output logic                        done_valid,
    output logic [id_width(NUM_REQ)-1:0] done_id,
    output logic [WORD_W-1:0]           done_data,
    output logic                        timeout,
    output logic                        busy
`ifdef SER_SCHED_CHECK_EN
    ,
    output logic                        mismatch
`endif
);

    localparam int unsigned ID_W   = id_width(NUM_REQ);
    localparam int unsigned CNT_W  = $clog2(WORD_W);
    localparam int unsigned WCNT_W = $clog2(WAIT_MAX);

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    bit_cnt, bit_cnt_nxt;
    logic [WCNT_W-1:0]   wait_cnt, wait_cnt_nxt;
    logic [WORD_W-1:0]   shreg, shreg_nxt;
    logic [ID_W-1:0]     cur_id, cur_id_nxt;
    logic [ID_W-1:0]     last_grant, last_grant_nxt;

    logic [NUM_REQ-1:0]  req_ready_nxt;
    logic                rx_data_nxt;
    logic                rx_val_nxt;
    logic [IDX_W-1:0]    index_nxt;
    logic                done_valid_nxt;
    logic [ID_W-1:0]     done_id_nxt;
    logic [WORD_W-1:0]   done_data_nxt;
    logic                timeout_nxt;
`ifdef SER_SCHED_CHECK_EN
    logic                mismatch_nxt;
`endif

    logic [NUM_REQ-1:0]  pick_grant;
    logic [ID_W-1:0]     pick_id;
    logic                pick_any;

    rr_pick #(
        .N  (NUM_REQ),
        .IW (ID_W)
    ) u_pick (
        .req   (req_valid),
        .last  (last_grant),
        .grant (pick_grant),
        .id    (pick_id),
        .any   (pick_any)
    );

    always_comb begin
        state_nxt      = state;
        bit_cnt_nxt    = bit_cnt;
        wait_cnt_nxt   = wait_cnt;
        shreg_nxt      = shreg;
        cur_id_nxt     = cur_id;
        last_grant_nxt = last_grant;
        req_ready_nxt  = '0;
        rx_data_nxt    = 1'b0;
        rx_val_nxt     = 1'b0;
        index_nxt      = index;
        done_valid_nxt = 1'b0;
        done_id_nxt    = done_id;
        done_data_nxt  = done_data;
        timeout_nxt    = 1'b0;
`ifdef SER_SCHED_CHECK_EN
        mismatch_nxt   = 1'b0;
`endif
        unique case (state)
            IDLE: begin
                wait_cnt_nxt = '0;
                if (pick_any) begin
                    req_ready_nxt  = pick_grant;
                    cur_id_nxt     = pick_id;
                    last_grant_nxt = pick_id;
                    bit_cnt_nxt    = '0;
                    state_nxt      = SHIFT;
                    for (int unsigned i = 0; i < NUM_REQ; i++) begin
                        if (pick_grant[i]) shreg_nxt = req_data[i*WORD_W +: WORD_W];
                    end
                end
            end
            SHIFT: begin
                rx_val_nxt  = 1'b1;
                rx_data_nxt = shreg[bit_cnt];
                index_nxt   = IDX_W'(bit_cnt);
                bit_cnt_nxt = bit_cnt + CNT_W'(1);
                if (bit_cnt == CNT_W'(WORD_W - 1)) begin
                    state_nxt    = WAIT_RDY;
                    wait_cnt_nxt = '0;
                end
            end
            WAIT_RDY: begin
                wait_cnt_nxt = wait_cnt + WCNT_W'(1);
                // tx_rdy takes priority over an expiry landing on the same cycle
                if (tx_rdy) begin
                    done_valid_nxt = 1'b1;
                    done_id_nxt    = cur_id;
                    done_data_nxt  = tx_data;
`ifdef SER_SCHED_CHECK_EN
                    mismatch_nxt   = (tx_data != shreg);
`endif
                    state_nxt      = IDLE;
                end else if (wait_cnt == WCNT_W'(WAIT_MAX - 1)) begin
                    timeout_nxt = 1'b1;
                    state_nxt   = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            wait_cnt   <= '0;
            shreg      <= '0;
            cur_id     <= '0;
            last_grant <= ID_W'(NUM_REQ - 1);
            req_ready  <= '0;
            rx_data    <= 1'b0;
            rx_val     <= 1'b0;
            index      <= '0;
            done_valid <= 1'b0;
            done_id    <= '0;
            done_data  <= '0;
            timeout    <= 1'b0;
            busy       <= 1'b0;
`ifdef SER_SCHED_CHECK_EN
            mismatch   <= 1'b0;
`endif
        end else begin
            state      <= state_nxt;
            bit_cnt    <= bit_cnt_nxt;
            wait_cnt   <= wait_cnt_nxt;
            shreg      <= shreg_nxt;
            cur_id     <= cur_id_nxt;
            last_grant <= last_grant_nxt;
            req_ready  <= req_ready_nxt;
            rx_data    <= rx_data_nxt;
            rx_val     <= rx_val_nxt;
            index      <= index_nxt;
            done_valid <= done_valid_nxt;
            done_id    <= done_id_nxt;
            done_data  <= done_data_nxt;
            timeout    <= timeout_nxt;
            busy       <= (state_nxt != IDLE);
`ifdef SER_SCHED_CHECK_EN
            mismatch   <= mismatch_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_ser_word_sched.sv
// Scoreboard bench for ser_word_sched with a simple deserializer model driving tx_rdy/tx_data.
// Build with SER_SCHED_CHECK_EN defined to also exercise the mismatch output.
module tb_ser_word_sched;

    localparam logic [31:0] D0 = 32'hA5A5_0F0F;
    localparam logic [31:0] D1 = 32'h1234_5678;
    localparam logic [31:0] D2 = 32'hFFFF_0000;
    localparam logic [31:0] D3 = 32'h8000_0001;

    logic         clk;
    logic         rst;
    logic [3:0]   req_valid;
    logic [127:0] req_data;
    logic [3:0]   req_ready;
    logic         rx_data;
    logic         rx_val;
    logic [31:0]  index;
    logic         tx_rdy;
    logic [31:0]  tx_data;
    logic         done_valid;
    logic [2:0]   done_id;
    logic [31:0]  done_data;
    logic         timeout;
    logic         busy;
`ifdef SER_SCHED_CHECK_EN
    logic         mismatch;
`endif

    ser_word_sched #(
        .NUM_REQ  (4),
        .WORD_W   (32),
        .WAIT_MAX (64)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .rx_data    (rx_data),
        .rx_val     (rx_val),
        .index      (index),
        .tx_rdy     (tx_rdy),
        .tx_data    (tx_data),
        .done_valid (done_valid),
        .done_id    (done_id),
        .done_data  (done_data),
        .timeout    (timeout),
        .busy       (busy)
`ifdef SER_SCHED_CHECK_EN
        ,
        .mismatch   (mismatch)
`endif
    );

    typedef struct {
        bit          to;
        logic [2:0]  id;
        logic [31:0] data;
        bit          mism;
        int          lat;
    } cmp_t;

    logic [3:0] gq[$];
    logic [5:0] bq[$];
    cmp_t       cq[$];

    int          passed = 0;
    int          total  = 0;
    int          cyc    = 0;
    int          last_cyc = 0;
    int          dly    = 2;
    logic [31:0] corrupt = '0;
    logic [31:0] asm_w  = '0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, act=running req=finished");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic push_word(input int id, input logic [31:0] w, input bit to,
                             input logic [31:0] rdata, input bit mism, input int lat);
        cmp_t c;
        gq.push_back(4'(1 << id));
        for (int i = 0; i < 32; i++) bq.push_back({w[i], 5'(i)});
        c.to = to; c.id = 3'(id); c.data = rdata; c.mism = mism; c.lat = lat;
        cq.push_back(c);
    endtask

    task automatic send_one(input int id);
        bit seen = 0;
        req_valid[id] = 1'b1;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (req_ready != 4'b0) seen = 1;
        end
        req_valid = '0;
        chk("grant_seen", 64'(seen), 64'd1);
    endtask

    task automatic count_grants(input int n);
        int got = 0;
        for (int i = 0; i < 1000 && got < n; i++) begin
            @(negedge clk);
            if (req_ready != 4'b0) got++;
        end
        req_valid = '0;
        chk("grant_count", 64'(got), 64'(n));
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (gq.size() == 0 && bq.size() == 0 && cq.size() == 0) break;
        end
        chk("drain", 64'(gq.size() + bq.size() + cq.size()), 64'd0);
        repeat (2) @(negedge clk);
    endtask

    // Deserializer model: rebuilds the word from the beats, answers dly cycles after the last one.
    initial begin
        tx_rdy  = 1'b0;
        tx_data = '0;
        forever begin
            @(negedge clk);
            if (rst && rx_val) begin
                asm_w[index[4:0]] = rx_data;
                if (index == 32'd31 && dly >= 0) begin
                    repeat (dly) @(negedge clk);
                    tx_data = asm_w ^ corrupt;
                    tx_rdy  = 1'b1;
                    @(negedge clk);
                    tx_rdy  = 1'b0;
                end
            end
        end
    end

    // Monitor: pops and compares whenever the DUT presents a grant, beat or completion.
    initial begin
        logic [3:0] g;
        logic [5:0] b;
        cmp_t       c;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                if (req_ready != 4'b0) begin
                    if (gq.size() == 0) chk("grant_unexpected", 64'(req_ready), 64'd0);
                    else begin
                        g = gq.pop_front();
                        chk("grant", 64'(req_ready), 64'(g));
                    end
                end
                if (rx_val) begin
                    if (bq.size() == 0) chk("beat_unexpected", 64'(index), 64'hFFFF);
                    else begin
                        b = bq.pop_front();
                        chk("beat_data", 64'(rx_data), 64'(b[5]));
                        chk("beat_index", 64'(index), 64'(b[4:0]));
                    end
                    if (index == 32'd31) last_cyc = cyc;
                end
                if (done_valid || timeout) begin
                    if (cq.size() == 0) chk("completion_unexpected", 64'(done_valid), 64'd0);
                    else begin
                        c = cq.pop_front();
                        chk("timeout", 64'(timeout), 64'(c.to));
                        chk("done_valid", 64'(done_valid), 64'(!c.to));
                        chk("completion_latency", 64'(cyc - last_cyc), 64'(c.lat));
                        if (!c.to) begin
                            chk("done_id", 64'(done_id), 64'(c.id));
                            chk("done_data", 64'(done_data), 64'(c.data));
`ifdef SER_SCHED_CHECK_EN
                            chk("mismatch", 64'(mismatch), 64'(c.mism));
`endif
                        end
                    end
                end
            end
        end
    end

    initial begin
        bit found;
        rst       = 1'b1;
        req_valid = '0;
        req_data  = {D3, D2, D1, D0};
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_req_ready", 64'(req_ready), 64'd0);
        chk("reset_rx_val", 64'(rx_val), 64'd0);
        chk("reset_rx_data", 64'(rx_data), 64'd0);
        chk("reset_index", 64'(index), 64'd0);
        chk("reset_done_valid", 64'(done_valid), 64'd0);
        chk("reset_done_data", 64'(done_data), 64'd0);
        chk("reset_timeout", 64'(timeout), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst = 1'b1;

        // Round-robin with all producers pending: 0,1,2,3,0
        dly = 2;
        push_word(0, D0, 0, D0, 0, 3);
        push_word(1, D1, 0, D1, 0, 3);
        push_word(2, D2, 0, D2, 0, 3);
        push_word(3, D3, 0, D3, 0, 3);
        push_word(0, D0, 0, D0, 0, 3);
        req_valid = 4'hF;
        count_grants(5);
        wait_drain();

        // Single word; req_data changed after grant must not affect it
        push_word(0, D0, 0, D0, 0, 3);
        send_one(0);
        req_data[31:0] = 32'hDEAD_BEEF;
        wait_drain();
        req_data[31:0] = D0;

        // Timeout, then a normal word
        dly = -1;
        push_word(2, D2, 1, '0, 0, 64);
        send_one(2);
        wait_drain();
        dly = 2;
        push_word(1, D1, 0, D1, 0, 3);
        send_one(1);
        wait_drain();

        // tx_rdy on the expiry cycle wins
        dly = 63;
        push_word(3, D3, 0, D3, 0, 64);
        send_one(3);
        wait_drain();
        dly = 2;

        // Reset during bit 10 of a word from producer 1
        push_word(1, D1, 0, D1, 0, 3);
        req_valid = 4'b0010;
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            #2;
            if (rx_val && index == 32'd10) found = 1;
        end
        chk("reach_bit10", 64'(found), 64'd1);
        rst = 1'b0;
        #1;
        chk("midreset_rx_val", 64'(rx_val), 64'd0);
        chk("midreset_index", 64'(index), 64'd0);
        chk("midreset_busy", 64'(busy), 64'd0);
        chk("midreset_done_valid", 64'(done_valid), 64'd0);
        chk("midreset_timeout", 64'(timeout), 64'd0);
        gq.delete();
        bq.delete();
        cq.delete();
        req_valid = 4'b0011;
        push_word(0, D0, 0, D0, 0, 3);
        push_word(1, D1, 0, D1, 0, 3);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        count_grants(2);
        wait_drain();

`ifdef SER_SCHED_CHECK_EN
        corrupt = 32'h1;
        push_word(0, D0, 0, 32'hA5A5_0F0E, 1, 3);
        send_one(0);
        wait_drain();
        corrupt = '0;
        push_word(0, D0, 0, D0, 0, 3);
        send_one(0);
        wait_drain();
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
